score_matrix_ctrl: RTL and testbench

SCORE_MATRIX_CTRL -- requirements
Module: score_matrix_ctrl

---
 rtl/score_matrix_ctrl.sv | 219 +++++++++++++++++++++
 tb/tb_score_matrix_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/score_matrix_ctrl.sv
// score_matrix_ctrl
//   Controller and score RAM for a dynamic-programming score matrix of
//   (N+1)x(N+1) signed cells. On start it fills row 0 and column 0 with
//   linear gap penalties. After that it serves neighbour reads
//   (diag/up/left of cell (i,j)) and single-cell writes from a compute stage.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   start      request boundary initialisation (accepted in IDLE/READY)
//   init_done  one-cycle pulse after the last boundary cell is written
//   rd_req     request neighbours of (i,j) (accepted in READY only)
//   wr_req     write wr_data to (i,j) (accepted in READY and while reading)
//   i, j       cell coordinates, valid range 1..N
//   wr_data    signed score to store
//   rd_valid   one-cycle pulse, diag/up/left valid (held until next pulse)
//   diag/up/left  cells (i-1,j-1), (i-1,j), (i,j-1)
//   busy       high in every state except IDLE and READY
//   err        sticky protocol error, cleared by reset or an accepted start
//
// Build option
//   SCORE_FWD_EN: keeps the most recently written cell in a forward register.
//   A read whose left neighbour is that cell skips the RAM read of the left
//   operand, so rd_valid arrives after 3 cycles instead of 4.
module score_matrix_ctrl #(
  parameter int N   = 128,
  parameter int W   = 9,
  parameter int GAP = 2,
  localparam int AW = $clog2(N+1),
  localparam int RW = $clog2((N+1)*(N+1))
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                init_done,
  input  logic                rd_req,
  input  logic                wr_req,
  input  logic [AW-1:0]       i,
  input  logic [AW-1:0]       j,
  input  logic signed [W-1:0] wr_data,
  output logic                rd_valid,
  output logic signed [W-1:0] diag,
  output logic signed [W-1:0] up,
  output logic signed [W-1:0] left,
  output logic                busy,
  output logic                err
);

  localparam int KW = $clog2(2*N+1);
  localparam logic [AW-1:0]       IMAX    = AW'(N);
  localparam logic [KW-1:0]       KMID    = KW'(N);
  localparam logic [KW-1:0]       KEND    = KW'(2*N);
  localparam logic [RW-1:0]       ROWSTEP = RW'(N+1);
  localparam logic signed [W-1:0] GAPV    = W'(GAP);

  typedef enum logic [2:0] {IDLE, INIT, READY, RD_D, RD_U, RD_L, OUT} state_t;

  function automatic logic [RW-1:0] cell_addr(input logic [AW-1:0] ci,
                                              input logic [AW-1:0] cj);
    return RW'(ci) * ROWSTEP + RW'(cj);
  endfunction

  state_t                state;
  logic [KW-1:0]         k;
  logic [RW-1:0]         init_addr;
  logic signed [W-1:0]   init_val;
  logic [AW-1:0]         ri, rj;
  logic signed [W-1:0]   dtmp, utmp, rdata;
  logic signed [W-1:0]   mem [0:(N+1)*(N+1)-1];

  logic                  in_range, wr_state, start_ok, rd_ok, wr_ok, err_set;
  logic                  we, rd_en;
  logic [RW-1:0]         waddr, raddr, left_addr;
  logic signed [W-1:0]   wdata;
  logic                  hit;
  logic signed [W-1:0]   lat_left;

  // Request qualification; an accepted start overrides any request in the same cycle.
  always_comb begin
    in_range = (i != '0) && (i <= IMAX) && (j != '0) && (j <= IMAX);
    wr_state = state inside {READY, RD_D, RD_U, RD_L, OUT};
    start_ok = start && (state == IDLE || state == READY);
    rd_ok    = rd_req && in_range && (state == READY) && !start_ok;
    wr_ok    = wr_req && in_range && wr_state && !start_ok;
    err_set  = !start_ok && (start || (rd_req && !rd_ok) || (wr_req && !wr_ok));
  end

  always_comb begin
    left_addr = cell_addr(ri, rj - AW'(1));
    rd_en     = 1'b0;
    raddr     = '0;
    case (state)
      RD_D:    begin rd_en = 1'b1; raddr = cell_addr(ri - AW'(1), rj - AW'(1)); end
      RD_U:    begin rd_en = 1'b1; raddr = cell_addr(ri - AW'(1), rj);          end
      RD_L:    begin rd_en = 1'b1; raddr = left_addr;                           end
      default: ;
    endcase
    we    = (state == INIT) || wr_ok;
    waddr = (state == INIT) ? init_addr : cell_addr(i, j);
    wdata = (state == INIT) ? init_val  : wr_data;
  end

  // Score RAM: one write port, one registered read port with write-first bypass.
  always_ff @(posedge clk) begin
    if (we)
      mem[waddr] <= wdata;
    if (rd_en)
      rdata <= (we && waddr == raddr) ? wdata : mem[raddr];
  end

  // Operand staging: diag lands in rdata during RD_U, up during RD_L.
  always_ff @(posedge clk) begin
    if (state == RD_U) dtmp <= rdata;
    if (state == RD_L) utmp <= rdata;
  end

`ifdef SCORE_FWD_EN
  logic                fwd_vld;
  logic [AW-1:0]       fwd_i, fwd_j;
  logic signed [W-1:0] fwd_data;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fwd_vld  <= 1'b0;
      fwd_i    <= '0;
      fwd_j    <= '0;
      fwd_data <= '0;
      hit      <= 1'b0;
      lat_left <= '0;
    end else begin
      if (wr_ok) begin
        fwd_vld  <= 1'b1;
        fwd_i    <= i;
        fwd_j    <= j;
        fwd_data <= wr_data;
      end
      if (rd_ok) begin
        hit      <= fwd_vld && (fwd_i == i) && (fwd_j == j - AW'(1));
        lat_left <= fwd_data;
      end else if (wr_ok && state != READY && waddr == left_addr) begin
        // Left cell rewritten while the read is in flight: keep the newer value.
        lat_left <= wr_data;
      end
    end
  end
`else
  assign hit      = 1'b0;
  assign lat_left = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      k         <= '0;
      init_addr <= '0;
      init_val  <= '0;
      ri        <= '0;
      rj        <= '0;
      init_done <= 1'b0;
      rd_valid  <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      diag      <= '0;
      up        <= '0;
      left      <= '0;
    end else begin
      init_done <= 1'b0;
      rd_valid  <= 1'b0;
      if (start_ok)     err <= 1'b0;
      else if (err_set) err <= 1'b1;

      case (state)
        IDLE, READY: begin
          if (start_ok) begin
            state     <= INIT;
            busy      <= 1'b1;
            k         <= '0;
            init_addr <= '0;
            init_val  <= '0;
          end else if (rd_ok) begin
            state <= RD_D;
            busy  <= 1'b1;
            ri    <= i;
            rj    <= j;
          end
        end
        // Row 0 walks the address by 1, column 0 by N+1; the penalty restarts at -GAP.
        INIT: begin
          k <= k + KW'(1);
          if (k == KMID) begin
            init_addr <= ROWSTEP;
            init_val  <= -GAPV;
          end else begin
            init_addr <= (k < KMID) ? init_addr + RW'(1) : init_addr + ROWSTEP;
            init_val  <= init_val - GAPV;
          end
          if (k == KEND) begin
            state     <= READY;
            busy      <= 1'b0;
            init_done <= 1'b1;
          end
        end
        RD_D: state <= RD_U;
        RD_U: state <= hit ? OUT : RD_L;
        RD_L: state <= OUT;
        OUT: begin
          diag     <= dtmp;
          up       <= hit ? rdata : utmp;
          left     <= hit ? lat_left : rdata;
          rd_valid <= 1'b1;
          busy     <= 1'b0;
          state    <= READY;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_matrix_ctrl.sv
// Testbench for score_matrix_ctrl with N=4, W=9, GAP=2.
// Directed table of writes and neighbour reads with hand-computed results,
// followed by hand-written sequences for bypass, busy, error and reset cases.
module tb_score_matrix_ctrl;

  localparam int N = 4;
  localparam int W = 9;
  localparam int GAP = 2;
`ifdef SCORE_FWD_EN
  localparam int FL = 3;
`else
  localparam int FL = 4;
`endif

  logic              clk = 1'b0;
  logic              rst, start, rd_req, wr_req;
  logic [2:0]        i, j;
  logic signed [8:0] wr_data;
  logic              init_done, rd_valid, busy, err;
  logic signed [8:0] diag, up, left;

  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  score_matrix_ctrl #(.N(N), .W(W), .GAP(GAP)) dut (
    .clk(clk), .rst(rst), .start(start), .init_done(init_done),
    .rd_req(rd_req), .wr_req(wr_req), .i(i), .j(j), .wr_data(wr_data),
    .rd_valid(rd_valid), .diag(diag), .up(up), .left(left),
    .busy(busy), .err(err)
  );

  typedef struct {
    bit is_wr;
    int ci;
    int cj;
    int wd;
    int ed;
    int eu;
    int el;
    int elat;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input int got, input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", nm, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input int ci, input int cj, input int wd);
    i = 3'(ci); j = 3'(cj); wr_data = 9'(wd); wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
  endtask

  task automatic wait_valid(inout int lat);
    while (!rd_valid && lat < 12) begin
      tick();
      lat++;
    end
  endtask

  task automatic do_read(input int ci, input int cj, output int lat,
                         output int d, output int u, output int l);
    i = 3'(ci); j = 3'(cj); rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    lat = 0;
    wait_valid(lat);
    d = int'(diag); u = int'(up); l = int'(left);
  endtask

  task automatic do_init(input string nm);
    int cnt;
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({nm, " busy"}, int'(busy), 1);
    cnt = 0;
    while (!init_done && cnt < 40) begin
      tick();
      cnt++;
    end
    chk({nm, " cycles"}, cnt, 2*N+1);
    tick();
    chk({nm, " done pulse"}, int'(init_done), 0);
    chk({nm, " idle busy"}, int'(busy), 0);
  endtask

  initial begin
    int lat, d, u, l, nvalid;

    rst = 1'b0; start = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
    i = '0; j = '0; wr_data = '0;
    repeat (2) tick();
    chk("reset busy", int'(busy), 0);
    chk("reset err", int'(err), 0);
    chk("reset rd_valid", int'(rd_valid), 0);
    chk("reset init_done", int'(init_done), 0);
    chk("reset diag", int'(diag), 0);
    rst = 1'b1;
    tick();

    do_init("init1");

    tbl[0]  = '{0, 1, 1, 0,    0,    -2,   -2,   4};
    tbl[1]  = '{1, 1, 1, 5,    0,    0,    0,    0};
    tbl[2]  = '{0, 1, 2, 0,    -2,   -4,   5,    FL};
    tbl[3]  = '{1, 1, 2, 7,    0,    0,    0,    0};
    tbl[4]  = '{1, 2, 1, -3,   0,    0,    0,    0};
    tbl[5]  = '{0, 2, 2, 0,    5,    7,    -3,   FL};
    tbl[6]  = '{0, 2, 1, 0,    -2,   5,    -4,   4};
    tbl[7]  = '{1, 3, 3, 1,    0,    0,    0,    0};
    tbl[8]  = '{1, 3, 4, -1,   0,    0,    0,    0};
    tbl[9]  = '{1, 4, 4, -7,   0,    0,    0,    0};
    tbl[10] = '{1, 4, 3, 3,    0,    0,    0,    0};
    tbl[11] = '{0, 4, 4, 0,    1,    -1,   3,    FL};
    tbl[12] = '{1, 1, 3, 255,  0,    0,    0,    0};
    tbl[13] = '{1, 1, 4, -100, 0,    0,    0,    0};
    tbl[14] = '{1, 2, 3, -256, 0,    0,    0,    0};
    tbl[15] = '{0, 2, 4, 0,    255,  -100, -256, FL};

    for (int n = 0; n < 16; n++) begin
      if (tbl[n].is_wr) begin
        do_write(tbl[n].ci, tbl[n].cj, tbl[n].wd);
      end else begin
        do_read(tbl[n].ci, tbl[n].cj, lat, d, u, l);
        chk($sformatf("v%0d latency", n), lat, tbl[n].elat);
        chk($sformatf("v%0d diag", n), d, tbl[n].ed);
        chk($sformatf("v%0d up", n), u, tbl[n].eu);
        chk($sformatf("v%0d left", n), l, tbl[n].el);
        chk($sformatf("v%0d err", n), int'(err), 0);
      end
    end

    // Read and write of (2,2) together, then rewrite (1,1) as its diag read issues.
    i = 3'd2; j = 3'd2; wr_data = 9'sd11; rd_req = 1'b1; wr_req = 1'b1;
    tick();
    rd_req = 1'b0;
    i = 3'd1; j = 3'd1; wr_data = 9'sd9;
    tick();
    wr_req = 1'b0;
    lat = 1;
    wait_valid(lat);
    chk("bypass latency", lat, 4);
    chk("bypass diag", int'(diag), 9);
    chk("bypass up", int'(up), 7);
    chk("bypass left", int'(left), -3);
    tick();
    chk("rd_valid pulse", int'(rd_valid), 0);
    do_read(2, 3, lat, d, u, l);
    chk("same-cycle wr left", l, 11);
    chk("same-cycle wr up", u, 255);
    chk("same-cycle wr err", int'(err), 0);

    // Second rd_req arrives while the first read sits in RD_U.
    i = 3'd1; j = 3'd1; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    tick();
    i = 3'd2; j = 3'd2; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    lat = 2;
    wait_valid(lat);
    chk("busy rd latency", lat, 4);
    chk("busy rd diag", int'(diag), 0);
    chk("busy rd up", int'(up), -2);
    chk("busy rd left", int'(left), -2);
    chk("busy rd err", int'(err), 1);
    nvalid = 0;
    repeat (6) begin
      tick();
      if (rd_valid) nvalid++;
    end
    chk("busy rd extra valid", nvalid, 0);
    chk("mem[24]", int'(dut.mem[24]), -7);

    // Out-of-range coordinate: ignored, err sticky until the next start.
    do_init("init2");
    chk("start clears err", int'(err), 0);
    i = 3'd0; j = 3'd1; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    nvalid = 0;
    repeat (6) begin
      tick();
      if (rd_valid) nvalid++;
    end
    chk("i=0 no valid", nvalid, 0);
    chk("i=0 err", int'(err), 1);
    do_read(1, 1, lat, d, u, l);
    chk("err sticky", int'(err), 1);
    chk("after err up", u, -2);
    do_init("init3");
    chk("restart clears err", int'(err), 0);

    // Reset in the middle of INIT, after a rejected read flagged err.
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    i = 3'd1; j = 3'd1; rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    repeat (3) tick();
    chk("init rd err", int'(err), 1);
    chk("init busy", int'(busy), 1);
    #2 rst = 1'b0;
    #1;
    chk("mid-init rst busy", int'(busy), 0);
    chk("mid-init rst err", int'(err), 0);
    chk("mid-init rst init_done", int'(init_done), 0);
    chk("mid-init rst up", int'(up), 0);
    chk("mid-init rst left", int'(left), 0);
    #2 rst = 1'b1;
    tick();
    do_init("init4");
    do_read(1, 1, lat, d, u, l);
    chk("post-rst latency", lat, 4);
    chk("post-rst diag", d, 0);
    chk("post-rst up", u, -2);
    chk("post-rst left", l, -2);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
